// File: rtl/apb4_timer_irq_arb.sv
// Claim/complete interrupt arbiter: edge-detects timer irq lines, masks and arbitrates them onto one CPU irq.
// Define TIMER_IRQ_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module apb4_timer_irq_arb #(
  parameter int unsigned SRC_NUM = 4,
  parameter int unsigned ID_W    = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [SRC_NUM-1:0] src_i,
  output logic               irq_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ASSERT = 2'd1, S_CLAIMED = 2'd2} state_e;

  localparam logic [1:0] REG_PEND  = 2'b00;
  localparam logic [1:0] REG_MASK  = 2'b01;
  localparam logic [1:0] REG_CLAIM = 2'b10;
  localparam logic [1:0] REG_CMPL  = 2'b11;

  state_e             state_q, state_d;
  logic [SRC_NUM-1:0] src_q, pend_q, pend_d, mask_q, mask_d;
  logic [SRC_NUM-1:0] live, set_v, clr_v;
  logic [ID_W-1:0]    win_q, win_d, arb_id;
  logic [1:0]         sel;
  logic               rd_acc, wr_acc, claim, cmpl_wr, cmpl_ok;
  logic               unused_apb;

`ifdef TIMER_IRQ_ARB_RR_EN
  logic [ID_W-1:0]    ptr_q, ptr_d;
  int unsigned        rr_idx;
`endif

  assign sel     = paddr[3:2];
  assign rd_acc  = psel & penable & ~pwrite;
  assign wr_acc  = psel & penable & pwrite;
  assign live    = pend_q & mask_q;
  assign set_v   = src_i & ~src_q;
  assign claim   = rd_acc && (sel == REG_CLAIM) && (state_q == S_ASSERT);
  assign cmpl_wr = wr_acc && (sel == REG_CMPL);
  assign cmpl_ok = cmpl_wr && (state_q == S_CLAIMED) && (pwdata[ID_W-1:0] == win_q);
  assign pready  = 1'b1;
  assign irq_o   = (state_q == S_ASSERT);
  assign unused_apb = ^{paddr[31:4], paddr[1:0], pwdata};

  // Arbiter: the lowest offset from the search start wins (the loop runs downward so it overwrites).
  always_comb begin
    arb_id = '0;
`ifdef TIMER_IRQ_ARB_RR_EN
    rr_idx = 0;
    for (int i = int'(SRC_NUM) - 1; i >= 0; i--) begin
      rr_idx = 32'(i) + 32'(ptr_q);
      if (rr_idx >= SRC_NUM) rr_idx = rr_idx - SRC_NUM;
      if (live[rr_idx[ID_W-1:0]]) arb_id = rr_idx[ID_W-1:0];
    end
`else
    for (int i = int'(SRC_NUM) - 1; i >= 0; i--) begin
      if (live[i]) arb_id = ID_W'(i);
    end
`endif
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (|live) state_d = S_ASSERT;
      S_ASSERT: begin
        if (claim)              state_d = S_CLAIMED;
        else if (!live[win_q])  state_d = S_IDLE;
      end
      S_CLAIMED: if (cmpl_ok) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Register updates and APB response; a new edge beats a same-cycle clear of the same bit.
  always_comb begin
    clr_v   = '0;
    mask_d  = mask_q;
    win_d   = win_q;
    prdata  = '0;
    pslverr = cmpl_wr & ~cmpl_ok;
`ifdef TIMER_IRQ_ARB_RR_EN
    ptr_d   = ptr_q;
    if (claim) ptr_d = (win_q == ID_W'(SRC_NUM - 1)) ? '0 : win_q + ID_W'(1);
`endif
    if (wr_acc && (sel == REG_PEND)) clr_v = pwdata[SRC_NUM-1:0];
    if (claim) clr_v[win_q] = 1'b1;
    pend_d = (pend_q & ~clr_v) | set_v;
    if (wr_acc && (sel == REG_MASK)) mask_d = pwdata[SRC_NUM-1:0];
    if ((state_q == S_IDLE) && (|live)) win_d = arb_id;
    if (rd_acc) begin
      case (sel)
        REG_PEND:  prdata = 32'(pend_q);
        REG_MASK:  prdata = 32'(mask_q);
        REG_CLAIM: prdata = (state_q == S_ASSERT) ? (32'h8000_0000 | 32'(win_q)) : 32'h0;
        default:   prdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      src_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      win_q  <= '0;
`ifdef TIMER_IRQ_ARB_RR_EN
      ptr_q  <= '0;
`endif
    end else begin
      src_q  <= src_i;
      pend_q <= pend_d;
      mask_q <= mask_d;
      win_q  <= win_d;
`ifdef TIMER_IRQ_ARB_RR_EN
      ptr_q  <= ptr_d;
`endif
    end
  end

endmodule
